tm_mem_arbiter: RTL

- Shares the Turing machine's single-port synchronous memory (program table plus tape) between two requesters.
- Requester 0 is the core: the Turing machine datapath/FSM. Requester 1 is the host: a debug/dump port that reads or patches program and tape contents while the machine runs or is halted.
- Core has priority. A wait counter guarantees the host forward progress.
- Sits between both requesters and the memory instance. Issues exactly one memory command per cycle.

---
 rtl/tm_mem_arbiter_if.sv | 53 +++++
 rtl/tm_mem_arbiter.sv | 104 ++++++++++
 2 files changed

// File: rtl/tm_mem_arbiter_if.sv
// Bundle of core/host request ports and the single-port memory bus seen by tm_mem_arbiter.
// core_lock exists only when TM_ARB_LOCK_EN is defined.
interface tm_mem_arbiter_if #(
  parameter int dw = 4,
  parameter int aw = 6
);
  logic          core_req;
  logic          core_we;
  logic [aw-1:0] core_addr;
  logic [dw-1:0] core_wdata;
  logic          core_gnt;
  logic          core_rvalid;
`ifdef TM_ARB_LOCK_EN
  logic          core_lock;
`endif
  logic          host_req;
  logic          host_we;
  logic [aw-1:0] host_addr;
  logic [dw-1:0] host_wdata;
  logic          host_gnt;
  logic          host_rvalid;
  logic [dw-1:0] rdata;
  logic          mem_re;
  logic          mem_we;
  logic [aw-1:0] mem_addr;
  logic [dw-1:0] mem_wdata;
  logic [dw-1:0] mem_rdata;
  logic [3:0]    host_wait;

  // Arbiter side
  modport slave (
`ifdef TM_ARB_LOCK_EN
    input  core_lock,
`endif
    input  core_req, core_we, core_addr, core_wdata,
    input  host_req, host_we, host_addr, host_wdata,
    input  mem_rdata,
    output core_gnt, core_rvalid, host_gnt, host_rvalid, rdata,
    output mem_re, mem_we, mem_addr, mem_wdata, host_wait
  );

  // Requesters plus memory side
  modport master (
`ifdef TM_ARB_LOCK_EN
    output core_lock,
`endif
    output core_req, core_we, core_addr, core_wdata,
    output host_req, host_we, host_addr, host_wdata,
    output mem_rdata,
    input  core_gnt, core_rvalid, host_gnt, host_rvalid, rdata,
    input  mem_re, mem_we, mem_addr, mem_wdata, host_wait
  );
endinterface

// File: rtl/tm_mem_arbiter.sv
// Core-priority arbiter for the Turing machine's single-port memory, with a host starvation bound.
// Optional TM_ARB_LOCK_EN adds core_lock to block host grants during core read-modify-write.
module tm_mem_arbiter #(
  parameter int dw       = 4,
  parameter int w        = 64,
  parameter int aw       = $clog2(w),
  parameter int MAX_WAIT = 4
) (
  input logic              i_clock,
  input logic              i_reset,
  tm_mem_arbiter_if.slave  bus
);

  if (MAX_WAIT < 1 || MAX_WAIT > 15 || aw < $clog2(w)) begin : g_bad_cfg
    $error("tm_mem_arbiter: MAX_WAIT must be 1..15 and aw must cover w");
  end

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] CORE       = 2'd1;
  localparam logic [1:0] HOST       = 2'd2;
  localparam logic [3:0] MAX_WAIT_L = 4'(MAX_WAIT);

  logic [1:0] r_state;
  logic [1:0] w_state_next;
  logic       r_was_read;
  logic [3:0] r_host_wait;
  logic [3:0] w_host_wait_next;
  logic       w_core_gnt;
  logic       w_host_gnt;
  logic       w_lock;
  logic       w_rvalid_any;

`ifdef TM_ARB_LOCK_EN
  assign w_lock = bus.core_lock && (r_state == CORE);
`else
  assign w_lock = 1'b0;
`endif

  // Host wins when core is idle or when the host has waited MAX_WAIT contended cycles.
  always_comb begin
    w_core_gnt = 1'b0;
    w_host_gnt = 1'b0;
    if (!i_reset) begin
      if (bus.host_req && !w_lock && (!bus.core_req || r_host_wait == MAX_WAIT_L)) begin
        w_host_gnt = 1'b1;
      end else if (bus.core_req) begin
        w_core_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    bus.mem_re    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    w_state_next  = IDLE;
    if (w_host_gnt) begin
      bus.mem_re    = !bus.host_we;
      bus.mem_we    = bus.host_we;
      bus.mem_addr  = bus.host_addr;
      bus.mem_wdata = bus.host_wdata;
      w_state_next  = HOST;
    end else if (w_core_gnt) begin
      bus.mem_re    = !bus.core_we;
      bus.mem_we    = bus.core_we;
      bus.mem_addr  = bus.core_addr;
      bus.mem_wdata = bus.core_wdata;
      w_state_next  = CORE;
    end
  end

  always_comb begin
    if (!bus.host_req || w_host_gnt) begin
      w_host_wait_next = 4'd0;
    end else if (r_host_wait < MAX_WAIT_L) begin
      w_host_wait_next = r_host_wait + 4'd1;
    end else begin
      w_host_wait_next = r_host_wait;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_was_read  <= 1'b0;
      r_host_wait <= 4'd0;
    end else begin
      r_state     <= w_state_next;
      r_was_read  <= bus.mem_re;
      r_host_wait <= w_host_wait_next;
    end
  end

  // The state records who was granted last cycle, which selects the rvalid owner.
  assign bus.core_rvalid = r_was_read && (r_state == CORE);
  assign bus.host_rvalid = r_was_read && (r_state == HOST);
  assign w_rvalid_any    = bus.core_rvalid || bus.host_rvalid;
  assign bus.rdata       = w_rvalid_any ? bus.mem_rdata : '0;
  assign bus.core_gnt    = w_core_gnt;
  assign bus.host_gnt    = w_host_gnt;
  assign bus.host_wait   = r_host_wait;

endmodule
